// File: rtl/aes_result_collector.sv
// Return-path collector for the three AES engines: re-orders finished blocks into dispatch
// order, streams them out over valid/ready and releases each engine with a one-cycle ack.
module aes_result_collector #(
    parameter int DATA_W      = 128,
    parameter int ORDER_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic [1:0]        disp_id,
    input  logic              disp_encrypt,
    input  logic              ready1,
    input  logic              ready2,
    input  logic              ready3,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    output logic              ack1,
    output logic              ack2,
    output logic              ack3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_encrypt,
    output logic [2:0]        pending,
    output logic              err
);

    localparam int         PTR_W   = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(ORDER_DEPTH);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         fifo_q [ORDER_DEPTH];
    logic [2:0]         fifo_d [ORDER_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [2:0]         count_q, count_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_encrypt_q, out_encrypt_d;
    logic [2:0]         ack_q, ack_d;
    logic               err_q, err_d;

    logic [2:0]         head;
    logic [1:0]         hid;
    logic               head_ready_raw;
    logic [DATA_W-1:0]  head_result;
    logic [2:0]         head_mask;
    logic               empty, full, head_rdy, take, push, overflow, illegal;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = fifo_q[rd_ptr_q];
    assign hid   = head[2:1];
    assign empty = (count_q == 3'd0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        head_ready_raw = 1'b0;
        head_result    = '0;
        head_mask      = 3'b000;
        case (hid)
            2'd1: begin head_ready_raw = ready1; head_result = result1; head_mask = 3'b001; end
            2'd2: begin head_ready_raw = ready2; head_result = result2; head_mask = 3'b010; end
            2'd3: begin head_ready_raw = ready3; head_result = result3; head_mask = 3'b100; end
            default: ;
        endcase
    end

    // An engine still showing ready during its own ack cycle holds a stale result; never take it twice.
    assign head_rdy = !empty && head_ready_raw && ((ack_q & head_mask) == 3'b000);
    assign take     = head_rdy && (!out_valid || out_ready);
    assign illegal  = disp_valid && (disp_id == 2'd0);
    assign push     = disp_valid && (disp_id != 2'd0) && (!full || take);
    assign overflow = disp_valid && (disp_id != 2'd0) && full && !take;

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {disp_id, disp_encrypt};
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (take) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, take})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        err_d = err_q || overflow || illegal;
    end

    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_encrypt_d = out_encrypt_q;
        ack_d         = 3'b000;
        if (take) begin
            out_data_d    = head_result;
            out_encrypt_d = head[0];
            ack_d         = head_mask;
        end
        case (state_q)
            IDLE: begin
                if (take) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = take ? HOLD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= 3'd0;
            out_data_q    <= '0;
            out_encrypt_q <= 1'b0;
            ack_q         <= 3'b000;
            err_q         <= 1'b0;
            for (int i = 0; i < ORDER_DEPTH; i++) fifo_q[i] <= 3'b000;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            out_data_q    <= out_data_d;
            out_encrypt_q <= out_encrypt_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            fifo_q        <= fifo_d;
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign out_data    = out_data_q;
    assign out_encrypt = out_encrypt_q;
    assign ack1        = ack_q[0];
    assign ack2        = ack_q[1];
    assign ack3        = ack_q[2];
    assign pending     = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_result_collector.sv
// Scoreboard bench for aes_result_collector: expected blocks and ack order are queued at
// dispatch and retired when the collector delivers / acks them.
module tb_aes_result_collector;

    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          enc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid, disp_encrypt, out_ready;
    logic [1:0]    disp_id;
    logic [3:1]    eng_rdy;
    logic [DW-1:0] eng_res [1:3];
    logic          ack1, ack2, ack3, out_valid, out_encrypt, err;
    logic [DW-1:0] out_data;
    logic [2:0]    pending;
    logic [3:1]    acks, prev_ack;

    exp_t          exp_q [$];
    logic [1:0]    ord_q [$];
    logic [DW-1:0] pend1 [$];
    logic [DW-1:0] pend2 [$];
    logic [DW-1:0] pend3 [$];

    int   n_vec = 0, n_err = 0, n_out = 0, n_ack = 0;
    logic exp_err = 1'b0;
    bit   tog = 1'b0;

    assign acks = {ack3, ack2, ack1};

    always #5 clk = ~clk;

    aes_result_collector #(.DATA_W(DW), .ORDER_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_encrypt(disp_encrypt),
        .ready1(eng_rdy[1]), .ready2(eng_rdy[2]), .ready3(eng_rdy[3]),
        .result1(eng_res[1]), .result2(eng_res[2]), .result3(eng_res[3]),
        .ack1(ack1), .ack2(ack2), .ack3(ack3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_encrypt(out_encrypt),
        .pending(pending), .err(err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pend_size(input logic [1:0] id);
        case (id)
            2'd1: return pend1.size();
            2'd2: return pend2.size();
            2'd3: return pend3.size();
            default: return 0;
        endcase
    endfunction

    // One clock: scoreboard work at negedge, then advance to just after posedge.
    task automatic tick();
        exp_t e;
        logic [1:0] oid;
        @(negedge clk);
        if (!rst) begin
            for (int n = 1; n <= 3; n++) begin
                if (acks[n]) begin
                    chk("ack_once", {127'd0, prev_ack[n]}, 0);
                    chk("ack_ready", {127'd0, eng_rdy[n]}, 1);
                    if (ord_q.size() == 0) chk("ack_unexpected", ord_q.size(), 1);
                    else begin
                        oid = ord_q.pop_front();
                        chk("ack_order", n, oid);
                    end
                    eng_rdy[n] = 1'b0;
                    n_ack++;
                end
            end
            prev_ack = acks;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_unexpected", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_enc", {127'd0, out_encrypt}, {127'd0, e.enc});
                    n_out++;
                end
            end
            chk("pending", pending, ord_q.size());
            chk("err", {127'd0, err}, {127'd0, exp_err});
        end else begin
            prev_ack = '0;
        end
        @(posedge clk);
        #1;
        if (tog) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic disp(input logic [1:0] id, input logic enc, input logic [DW-1:0] data,
                        input bit accept);
        disp_valid   = 1'b1;
        disp_id      = id;
        disp_encrypt = enc;
        tick();
        disp_valid   = 1'b0;
        disp_id      = 2'd0;
        disp_encrypt = 1'b0;
        if (accept) begin
            exp_q.push_back('{data: data, enc: enc});
            ord_q.push_back(id);
            case (id)
                2'd1: pend1.push_back(data);
                2'd2: pend2.push_back(data);
                default: pend3.push_back(data);
            endcase
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic complete(input logic [1:0] id);
        case (id)
            2'd1: eng_res[1] = pend1.pop_front();
            2'd2: eng_res[2] = pend2.pop_front();
            default: eng_res[3] = pend3.pop_front();
        endcase
        eng_rdy[id] = 1'b1;
    endtask

    task automatic clear_model();
        exp_q.delete(); ord_q.delete();
        pend1.delete(); pend2.delete(); pend3.delete();
        exp_err  = 1'b0;
        eng_rdy  = '0;
        prev_ack = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        disp_valid = 1'b0; disp_id = 2'd0; disp_encrypt = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic drain(input int bound);
        out_ready = 1'b1;
        for (int w = 0; w < bound && exp_q.size() != 0; w++) begin
            if (ord_q.size() != 0 && !eng_rdy[ord_q[0]] && pend_size(ord_q[0]) != 0)
                complete(ord_q[0]);
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        logic [DW-1:0] da, db, dc, held;
        logic [1:0]    id;
        int            out0, ack0;

        rst = 1'b1; out_ready = 1'b1;
        disp_valid = 1'b0; disp_id = 2'd0; disp_encrypt = 1'b0;
        eng_rdy = '0; prev_ack = '0;
        for (int n = 1; n <= 3; n++) eng_res[n] = '0;

        // reset values
        do_reset(2);
        chk("rst_valid", {127'd0, out_valid}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_enc", {127'd0, out_encrypt}, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", {127'd0, err}, 0);
        chk("rst_acks", acks, 0);

        // 1: in-order completion, back-to-back delivery
        da = 128'hAAAA_0001_0000_0000_0000_0000_0000_000A;
        db = 128'hBBBB_0002_0000_0000_0000_0000_0000_000B;
        dc = 128'hCCCC_0003_0000_0000_0000_0000_0000_000C;
        disp(2'd1, 1'b1, da, 1);
        disp(2'd2, 1'b0, db, 1);
        disp(2'd3, 1'b1, dc, 1);
        chk("t1_pending3", pending, 3);
        complete(2'd1); complete(2'd2); complete(2'd3);
        tick();
        chk("t1_lat_valid", {127'd0, out_valid}, 1);
        chk("t1_lat_ack1", acks, 3'b001);
        chk("t1_out_a", out_data, da);
        tick();
        chk("t1_out_b", out_data, db);
        chk("t1_enc_b", {127'd0, out_encrypt}, 0);
        chk("t1_ack2", acks, 3'b010);
        tick();
        chk("t1_out_c", out_data, dc);
        chk("t1_ack3", acks, 3'b100);
        tick();
        chk("t1_idle", {127'd0, out_valid}, 0);
        chk("t1_pending0", pending, 0);

        // 2: out-of-order completion is held until the head finishes
        do_reset(1);
        disp(2'd1, 1'b0, 128'h11, 1);
        disp(2'd2, 1'b1, 128'h22, 1);
        disp(2'd3, 1'b0, 128'h33, 1);
        complete(2'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait3_valid", {127'd0, out_valid}, 0);
            chk("t2_wait3_ack", acks, 0);
        end
        complete(2'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait2_valid", {127'd0, out_valid}, 0);
        end
        complete(2'd1);
        drain(40);

        // 3: back-pressure freezes output and withholds the next ack
        do_reset(1);
        disp(2'd1, 1'b1, 128'hDEAD_BEEF, 1);
        disp(2'd2, 1'b0, 128'hFEED_F00D, 1);
        out_ready = 1'b0;
        complete(2'd1);
        tick();
        chk("t3_valid", {127'd0, out_valid}, 1);
        held = out_data;
        chk("t3_first", held, 128'hDEAD_BEEF);
        complete(2'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_valid", {127'd0, out_valid}, 1);
            chk("t3_stall_data", out_data, held);
            chk("t3_stall_ack", acks, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_next_ack2", acks, 3'b010);
        chk("t3_next_data", out_data, 128'hFEED_F00D);
        drain(40);

        // 4: overflow, then push+pop while full
        do_reset(1);
        disp(2'd1, 1'b1, 128'h4001, 1);
        disp(2'd2, 1'b0, 128'h4002, 1);
        disp(2'd3, 1'b1, 128'h4003, 1);
        disp(2'd1, 1'b0, 128'h4004, 1);
        chk("t4_full", pending, 4);
        chk("t4_err_before", {127'd0, err}, 0);
        disp(2'd2, 1'b1, 128'h4005, 0);
        chk("t4_full_drop", pending, 4);
        chk("t4_err_set", {127'd0, err}, 1);
        complete(2'd1);
        disp(2'd3, 1'b0, 128'h4006, 1);
        chk("t4_pushpop_pending", pending, 4);
        chk("t4_pushpop_err", {127'd0, err}, 1);
        drain(80);

        // 5: illegal id, then reset while holding a block
        do_reset(1);
        disp(2'd0, 1'b1, 128'h0, 0);
        chk("t5_illegal_err", {127'd0, err}, 1);
        chk("t5_illegal_pending", pending, 0);
        do_reset(1);
        disp(2'd1, 1'b0, 128'h51, 1);
        disp(2'd2, 1'b1, 128'h52, 1);
        disp(2'd3, 1'b0, 128'h53, 1);
        out_ready = 1'b0;
        complete(2'd1);
        tick();
        chk("t5_hold_valid", {127'd0, out_valid}, 1);
        chk("t5_hold_pending", pending, 2);
        do_reset(1);
        chk("t5_rst_valid", {127'd0, out_valid}, 0);
        chk("t5_rst_pending", pending, 0);
        chk("t5_rst_err", {127'd0, err}, 0);
        chk("t5_rst_data", out_data, 0);
        out_ready = 1'b1;
        tick();

        // 6: pointer wrap with random back-pressure
        do_reset(1);
        out0 = n_out;
        ack0 = n_ack;
        tog  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            id = 2'((i % 3) + 1);
            for (int w = 0; w < 60 && ord_q.size() >= 4; w++) tick();
            chk("t6_space", {127'd0, (ord_q.size() < 4)}, 1);
            disp(id, 1'(i), {$urandom, $urandom, $urandom, $urandom}, 1);
            for (int w = 0; w < 100 && eng_rdy[id]; w++) tick();
            chk("t6_eng_free", {127'd0, eng_rdy[id]}, 0);
            complete(id);
        end
        tog = 1'b0;
        drain(200);
        chk("t6_outs", n_out - out0, 20);
        chk("t6_acks", n_ack - ack0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
